// File: rtl/router_preprocess_ctrl_if.sv
// Snooped AXI-Stream bus bundle feeding the router preprocess control.
// master drives tdata/tvalid/tready/tlast; slave observes them.
interface router_preprocess_ctrl_if #(
  parameter int DW = 256
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (
    output tdata,
    output tvalid,
    output tready,
    output tlast
  );

  modport slave (
    input tdata,
    input tvalid,
    input tready,
    input tlast
  );
endinterface

// File: rtl/router_preprocess_ctrl.sv
// Word-position tracker, per-word strobes and IPv4 header check with a
// fall-through result FIFO ({is_ipv4, ip_checksum_ok, ttl_expired}).
module router_preprocess_ctrl #(
  parameter int C_S_AXIS_DATA_WIDTH    = 256,
  parameter int RESULT_FIFO_DEPTH_BITS = 2
) (
  input  logic clk,
  input  logic reset,
  router_preprocess_ctrl_if.slave s_axis,
  output logic word_MAC_HDR,
  output logic word_IP_DST_HI,
  output logic word_IP_DST_LO,
  output logic hdr_result_vld,
  output logic is_ipv4,
  output logic ip_checksum_ok,
  output logic ttl_expired,
  input  logic rd_hdr_result,
  output logic result_fifo_nearly_full,
  output logic result_overflow
);
  localparam int AW    = RESULT_FIFO_DEPTH_BITS;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    WORD0,
    WORD1,
    PAYLOAD
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] eth_q, eth_d;
  logic [7:0]  vihl_q, vihl_d;
  logic [7:0]  ttl_q, ttl_d;
  logic [19:0] psum_q, psum_d;

  logic        beat;
  logic        push;
  logic [2:0]  res;
  logic [19:0] psum_w;
  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic        ip_ok;
  logic        unused_bits;

  assign beat = s_axis.tvalid && s_axis.tready;
  assign unused_bits = ^s_axis.tdata[239:160];

  // Nine halfwords of word 0 that belong to the IP header.
  always_comb begin
    psum_w = '0;
    for (int i = 0; i < 9; i++) begin
      psum_w = psum_w + 20'(s_axis.tdata[16*i +: 16]);
    end
  end

  assign sum   = psum_q + 20'(s_axis.tdata[255:240]);
  assign fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
  assign fold2 = fold1[15:0] + 16'(fold1[16]);
  assign ip_ok = (eth_q == 16'h0800) && (vihl_q == 8'h45);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WORD0;
      eth_q   <= '0;
      vihl_q  <= '0;
      ttl_q   <= '0;
      psum_q  <= '0;
    end else begin
      state_q <= state_d;
      eth_q   <= eth_d;
      vihl_q  <= vihl_d;
      ttl_q   <= ttl_d;
      psum_q  <= psum_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    eth_d          = eth_q;
    vihl_d         = vihl_q;
    ttl_d          = ttl_q;
    psum_d         = psum_q;
    push           = 1'b0;
    res            = 3'b000;
    word_MAC_HDR   = 1'b0;
    word_IP_DST_HI = 1'b0;
    word_IP_DST_LO = 1'b0;
    unique case (state_q)
      WORD0: begin
        if (beat) begin
          word_MAC_HDR   = 1'b1;
          word_IP_DST_HI = 1'b1;
          if (s_axis.tlast) begin
            push = 1'b1;
          end else begin
            eth_d   = s_axis.tdata[159:144];
            vihl_d  = s_axis.tdata[143:136];
            ttl_d   = s_axis.tdata[79:72];
            psum_d  = psum_w;
            state_d = WORD1;
          end
        end
      end
      WORD1: begin
        if (beat) begin
          word_IP_DST_LO = 1'b1;
          push = 1'b1;
          res  = {ip_ok,
                  ip_ok && (fold2 == 16'hFFFF),
                  ip_ok && (ttl_q <= 8'd1)};
          state_d = s_axis.tlast ? WORD0 : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (beat && s_axis.tlast) begin
          state_d = WORD0;
        end
      end
      default: state_d = WORD0;
    endcase
  end

  logic [2:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          ovf_q;
  logic          full, empty, pop, wr_en;

  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign pop   = rd_hdr_result && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_q] <= res;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (wr_en && !pop) cnt_q <= cnt_q + 1'b1;
      else if (pop && !wr_en) cnt_q <= cnt_q - 1'b1;
      if (push && !wr_en) ovf_q <= 1'b1;
    end
  end

  assign hdr_result_vld = !empty;
  assign is_ipv4        = !empty && mem_q[rd_q][2];
  assign ip_checksum_ok = !empty && mem_q[rd_q][1];
  assign ttl_expired    = !empty && mem_q[rd_q][0];
  assign result_fifo_nearly_full =
    cnt_q >= (AW+1)'(DEPTH - 1);
  assign result_overflow = ovf_q;
endmodule

// File: tb/tb_router_preprocess_ctrl.sv
// Directed bench for router_preprocess_ctrl with a packet-level model
// checked every cycle, plus literal expectations per scenario.
module tb_router_preprocess_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rd = 1'b0;
  logic mac, dhi, dlo, vld, ipv4, ckok, ttlx, nf, ovf;

  router_preprocess_ctrl_if #(.DW(256)) bus ();

  router_preprocess_ctrl dut (
    .clk                     (clk),
    .reset                   (reset),
    .s_axis                  (bus.slave),
    .word_MAC_HDR            (mac),
    .word_IP_DST_HI          (dhi),
    .word_IP_DST_LO          (dlo),
    .hdr_result_vld          (vld),
    .is_ipv4                 (ipv4),
    .ip_checksum_ok          (ckok),
    .ttl_expired             (ttlx),
    .rd_hdr_result           (rd),
    .result_fifo_nearly_full (nf),
    .result_overflow         (ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // ---------------- model ----------------
  logic [2:0]   mq[$];
  int           widx = 0;
  logic [255:0] mw0 = '0;
  bit           movf = 0;
  int           mac_cnt = 0;
  int           lo_cnt = 0;

  function automatic logic [2:0] eval(logic [255:0] a,
                                      logic [255:0] b);
    logic [7:0] by [34];
    int s;
    logic ip;
    for (int n = 0; n < 32; n++) by[n] = a[255-8*n -: 8];
    by[32] = b[255:248];
    by[33] = b[247:240];
    s = 0;
    for (int i = 0; i < 10; i++)
      s += int'({by[14+2*i], by[15+2*i]});
    while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
    ip = ({by[12], by[13]} == 16'h0800) && (by[14] == 8'h45);
    return {ip, ip && (s == 'hFFFF), ip && (by[22] <= 8'd1)};
  endfunction

  initial begin
    logic b;
    logic [2:0] hd;
    logic [2:0] r;
    bit do_push;
    @(posedge clk);
    forever begin
      @(negedge clk);
      b = bus.tvalid && bus.tready;
      hd = (mq.size() > 0) ? mq[0] : 3'b000;
      chk("mdl_mac", 32'(mac), 32'(b && widx == 0));
      chk("mdl_dhi", 32'(dhi), 32'(b && widx == 0));
      chk("mdl_dlo", 32'(dlo), 32'(b && widx == 1));
      chk("mdl_vld", 32'(vld), 32'(mq.size() > 0));
      chk("mdl_head", 32'({ipv4, ckok, ttlx}), 32'(hd));
      chk("mdl_nf", 32'(nf), 32'(mq.size() >= 3));
      chk("mdl_ovf", 32'(ovf), 32'(movf));
      if (mac) mac_cnt++;
      if (dlo) lo_cnt++;
      if (reset) begin
        widx = 0;
        mq.delete();
        movf = 0;
      end else begin
        do_push = 0;
        r = 3'b000;
        if (b) begin
          if (widx == 0) mw0 = bus.tdata;
          if (widx == 0 && bus.tlast) do_push = 1;
          if (widx == 1) begin
            r = eval(mw0, bus.tdata);
            do_push = 1;
          end
          widx = bus.tlast ? 0 : widx + 1;
        end
        if (rd && mq.size() > 0) void'(mq.pop_front());
        if (do_push) begin
          if (mq.size() >= 4) movf = 1;
          else mq.push_back(r);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic hs [4];
  logic ls [4];
  logic vs [4];

  function automatic logic [255:0] mk0(logic [15:0] eth,
                                       logic [7:0] ttl,
                                       logic [15:0] ck);
    return {48'h001122334455, 48'h66778899aabb, eth,
            8'h45, 8'h00, 16'h0030, 16'h0000, 16'h4000,
            ttl, 8'h11, ck, 32'hc0a80001, 16'hc0a8};
  endfunction

  function automatic logic [255:0] mk1();
    return {16'h0102, {30{8'h5A}}};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [255:0] w0, input int nb,
                      input bit tog);
    for (int i = 0; i < 4; i++) begin
      hs[i] = 0; ls[i] = 0; vs[i] = 0;
    end
    for (int k = 0; k < nb; k++) begin
      bus.tvalid = 1'b1;
      bus.tdata  = (k == 0) ? w0 :
                   (k == 1) ? mk1() : {32{8'hA5}} ^ 256'(k);
      bus.tlast  = (k == nb - 1);
      if (tog) begin
        bus.tready = 1'b0;
        cyc();
      end
      bus.tready = 1'b1;
      @(negedge clk);
      if (k < 4) begin
        hs[k] = dhi; ls[k] = dlo; vs[k] = vld;
      end
      cyc();
    end
    bus.tvalid = 1'b0;
    bus.tready = 1'b0;
    bus.tlast  = 1'b0;
  endtask

  task automatic head(input string nm, input logic [2:0] exp);
    @(negedge clk);
    chk({nm, "_vld"}, 32'(vld), 32'd1);
    chk(nm, 32'({ipv4, ckok, ttlx}), 32'(exp));
    cyc();
    rd = 1'b1;
    cyc();
    rd = 1'b0;
  endtask

  localparam logic [15:0] CK  = 16'hB869;
  localparam logic [15:0] CK1 = 16'hF769;

  initial begin
    int m0, l0;
    bus.tdata = '0;
    bus.tvalid = 1'b0;
    bus.tready = 1'b0;
    bus.tlast = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_vld", 32'(vld), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_nf", 32'(nf), 32'd0);
    cyc();

    send(mk0(16'h0800, 8'd64, CK), 3, 0);
    chk("v_dhi0", 32'(hs[0]), 32'd1);
    chk("v_dlo0", 32'(ls[0]), 32'd0);
    chk("v_dhi1", 32'(hs[1]), 32'd0);
    chk("v_dlo1", 32'(ls[1]), 32'd1);
    chk("v_vld_b1", 32'(vs[1]), 32'd0);
    chk("v_vld_b2", 32'(vs[2]), 32'd1);
    head("v_res", 3'b110);

    send(mk0(16'h0800, 8'd64, CK ^ 16'h0001), 2, 0);
    head("badck", 3'b100);
    send(mk0(16'h0800, 8'd1, CK1), 2, 0);
    head("ttl1", 3'b111);
    send(mk0(16'h86DD, 8'd64, CK), 2, 0);
    head("ipv6", 3'b000);
    send(mk0(16'h0800, 8'd64, CK), 1, 0);
    head("runt", 3'b000);
    send(mk0(16'h0800, 8'd64, CK), 2, 0);
    chk("post_runt_hdr", 32'(hs[0]), 32'd1);
    head("post_runt", 3'b110);

    m0 = mac_cnt;
    l0 = lo_cnt;
    send(mk0(16'h0800, 8'd64, CK), 4, 1);
    send(mk0(16'h0800, 8'd64, CK ^ 16'h0001), 2, 0);
    @(negedge clk);
    chk("tog_mac_cnt", 32'(mac_cnt - m0), 32'd2);
    chk("tog_lo_cnt", 32'(lo_cnt - l0), 32'd2);
    cyc();
    head("tog_r0", 3'b110);
    head("tog_r1", 3'b100);

    send(mk0(16'h0800, 8'd64, CK), 2, 0);
    send(mk0(16'h0800, 8'd64, CK ^ 16'h0001), 2, 0);
    @(negedge clk);
    chk("nf_at2", 32'(nf), 32'd0);
    cyc();
    send(mk0(16'h0800, 8'd1, CK1), 2, 0);
    @(negedge clk);
    chk("nf_at3", 32'(nf), 32'd1);
    cyc();
    send(mk0(16'h86DD, 8'd64, CK), 2, 0);
    @(negedge clk);
    chk("ovf_at4", 32'(ovf), 32'd0);
    cyc();
    send(mk0(16'h0800, 8'd64, CK), 2, 0);
    @(negedge clk);
    chk("ovf_at5", 32'(ovf), 32'd1);
    cyc();
    head("pop0", 3'b110);
    head("pop1", 3'b100);
    head("pop2", 3'b111);
    head("pop3", 3'b000);
    @(negedge clk);
    chk("drained_vld", 32'(vld), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    cyc();

    bus.tvalid = 1'b1;
    bus.tready = 1'b1;
    bus.tlast = 1'b0;
    bus.tdata = mk0(16'h0800, 8'd64, CK);
    cyc();
    bus.tdata = mk1();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.tvalid = 1'b0;
    bus.tready = 1'b0;
    @(negedge clk);
    chk("abort_vld", 32'(vld), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    cyc();
    send(mk0(16'h0800, 8'd64, CK), 2, 0);
    chk("after_rst_hdr", 32'(hs[0]), 32'd1);
    head("after_rst", 3'b110);
    @(negedge clk);
    chk("after_rst_empty", 32'(vld), 32'd0);
    cyc();
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/router_preprocess_ctrl.md
# router_preprocess_ctrl

Snoops the 256-bit AXI-Stream bus entering the router output-port-lookup and tracks the word position within each packet. Generates the per-word strobes (`word_MAC_HDR`, `word_IP_DST_HI`, `word_IP_DST_LO`) consumed by the destination-IP filter and the other lookup stages. In parallel it validates the IPv4 header (ethertype, version/IHL, header checksum, TTL) and queues one result per packet for the process block.

## Interface

Parameters:
- `C_S_AXIS_DATA_WIDTH`, default 256: bus width. Only 256 is supported.
- `RESULT_FIFO_DEPTH_BITS`, default 2: log2 depth of the result FIFO.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `tdata`  in  256  snooped bus data. Byte n is `tdata[255-8n -: 8]`.
- `tvalid`  in  1  snooped valid.
- `tready`  in  1  snooped ready. A beat is `tvalid && tready`.
- `tlast`  in  1  snooped last.
- `word_MAC_HDR`  out  1  beat is word 0.
- `word_IP_DST_HI`  out  1  beat is word 0; dst IP bits [31:16] are at `tdata[15:0]`.
- `word_IP_DST_LO`  out  1  beat is word 1; dst IP bits [15:0] are at `tdata[255:240]`.
- `hdr_result_vld`  out  1  result FIFO not empty.
- `is_ipv4`  out  1  FIFO head: ethertype is 0x0800 and version/IHL byte is 0x45.
- `ip_checksum_ok`  out  1  FIFO head: header checksum is correct.
- `ttl_expired`  out  1  FIFO head: TTL is 0 or 1.
- `rd_hdr_result`  in  1  pop the FIFO head.
- `result_fifo_nearly_full`  out  1  one free entry or fewer remains.
- `result_overflow`  out  1  sticky; set when a result is dropped.

## Operation

- States: WORD0 (reset state), WORD1, PAYLOAD. State advances only on a beat.
- WORD0 beat with `tlast`=1 (runt packet):
  - push result {0,0,0};
  - stay in WORD0.
- WORD0 beat with `tlast`=0:
  - latch ethertype (bytes 12-13, `tdata[159:144]`), ver/IHL (`tdata[143:136]`) and TTL (`tdata[79:72]`);
  - latch the 20-bit partial sum of the 9 halfwords `tdata[143:0]`;
  - go to WORD1.
- WORD1 beat:
  - sum = partial + `tdata[255:240]`;
  - fold the carries twice into 16 bits;
  - `ip_checksum_ok` = (fold == 16'hFFFF);
  - `is_ipv4` = (ethertype == 16'h0800) && (ver/IHL == 8'h45);
  - `ttl_expired` = (TTL <= 1);
  - if `is_ipv4` is 0, force `ip_checksum_ok` and `ttl_expired` to 0;
  - push the result;
  - next state is WORD0 if `tlast`, else PAYLOAD.
- PAYLOAD beat with `tlast`=1: go to WORD0. All other PAYLOAD beats: stay in PAYLOAD.
- Strobes:
  - `word_MAC_HDR` = `word_IP_DST_HI` = (state == WORD0) && beat;
  - `word_IP_DST_LO` = (state == WORD1) && beat;
  - strobes are purely combinational, and none assert without a beat.
- Result FIFO: fall-through, {is_ipv4, ip_checksum_ok, ttl_expired} wide.
  - Push while full: the result is dropped, FIFO contents are unchanged, `result_overflow` is set.
  - Pop while empty: ignored.
  - Simultaneous push and pop while full: both take effect and nothing is dropped.
- Only IHL=5 headers are validated. Option-bearing headers report `is_ipv4`=0.

## Timing

- Strobes are asserted in the same cycle as the qualifying beat, so downstream stages register `tdata` on that edge.
- Result push is registered: the result is written at the clock edge ending the WORD1 beat (or the runt WORD0 beat).
- `hdr_result_vld` and the head fields are valid the next cycle. Minimum latency is 1 cycle after the beat.
- Head outputs change only on a pop or on a push into an empty FIFO.
- Reset values:
  - state = WORD0;
  - FIFO empty;
  - all outputs 0, including `result_overflow`;
  - latched fields 0.
- Reset mid-packet abandons the packet with no result. The first beat after reset is treated as word 0, so the bus must be reset together with this block.
- Back-to-back packets with no idle cycle: the beat following `tlast` is word 0 of the next packet.
- `tvalid` held high with `tready` low: state holds and no strobes assert.

## Test plan

- Valid packet: ethertype 0x0800, ver/IHL 0x45, TTL 64, correct checksum, dst 192.168.1.2, 3 beats.
  - Required: `word_IP_DST_HI` with `tdata[15:0]`=0xC0A8 on beat 0.
  - Required: `word_IP_DST_LO` with `tdata[255:240]`=0x0102 on beat 1.
  - Required: one cycle after beat 1, result {1,1,0} and `hdr_result_vld`=1.
- Same packet, checksum field XOR 0x0001 -> result {1,0,0}. Same packet, TTL=1 with checksum fixed up -> result {1,1,1}.
- Ethertype 0x86DD -> result {0,0,0}. Single-beat runt -> result {0,0,0}; the next beat strobes `word_MAC_HDR`.
- `tready` toggled 0/1 on every cycle across a 4-beat packet, followed by a back-to-back 2-beat packet.
  - Required: exactly one strobe triple per packet, each on its correct beat.
  - Required: two results pushed in order.
- Five packets with `rd_hdr_result`=0 (depth 4).
  - Required: `result_fifo_nearly_full`=1 after 3 results.
  - Required: 5th result dropped and `result_overflow`=1.
  - Required: popping returns the first 4 in order.
- Reset asserted on beat 1 of a packet, then a valid packet: no result from the aborted packet; the new packet yields {1,1,0}.
